beam_topk_sel: RTL and testbench

- Downstream of the per-beam antenna MAC/abs-sum stage. Consumes one correlation magnitude per beam per cycle.
- Accumulates each beam's magnitude over NRND rounds, then selects the K strongest beams for PUSCH dimension reduction.
- Emits the K beam indices with their accumulated powers as a serial stream, strongest first, toward the beam-selection/compression stage.

---
 rtl/beam_topk_sel_pkg.sv | 30 +++
 rtl/beam_topk_sel_if.sv | 31 +++
 rtl/beam_topk_sel_topk_insert.sv | 57 +++++
 rtl/beam_topk_sel.sv | 156 +++++++++++++++
 tb/tb_beam_topk_sel.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/beam_topk_sel_pkg.sv
// beam_sel_pkg: shared types and width helpers for the beam top-K selector.
//   state_t      - controller state encoding (IDLE/ACC/SORT/OUT)
//   topk_entry_t - one slot of the sorted top-K list (power, beam index, valid)
//   clog2_min1() - ceil(log2(n)) with a floor of 1, for counter widths
// Package types cannot follow module parameters, so the entry fields are
// sized for the widest supported instance; modules zero-extend into them
// and keep only their own low bits when reading back.
package beam_sel_pkg;

    localparam int PWR_W_MAX = 64;
    localparam int IDX_W_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_SORT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [PWR_W_MAX-1:0] pwr;
        logic [IDX_W_MAX-1:0] idx;
        logic                 vld;
    } topk_entry_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/beam_topk_sel_if.sv
// beam_topk_sel_if: input magnitude stream and selected-beam output stream.
//   i_sum_data/i_tvalid/i_sof         - per-beam magnitudes from the MAC stage
//   o_beam_idx/o_beam_pwr/o_tvalid/
//   o_tlast                           - K selected beams, strongest first
//   o_busy/o_drop                     - status: sorting/outputting, beat discarded
// Modports: master = upstream/downstream environment, slave = selector.
interface beam_topk_sel_if #(
    parameter int IW = 48,
    parameter int BW = 6,
    parameter int AW = 51
) ();
    logic [IW-1:0] i_sum_data;
    logic          i_tvalid;
    logic          i_sof;
    logic [BW-1:0] o_beam_idx;
    logic [AW-1:0] o_beam_pwr;
    logic          o_tvalid;
    logic          o_tlast;
    logic          o_busy;
    logic          o_drop;

    modport master (
        output i_sum_data, i_tvalid, i_sof,
        input  o_beam_idx, o_beam_pwr, o_tvalid, o_tlast, o_busy, o_drop
    );

    modport slave (
        input  i_sum_data, i_tvalid, i_sof,
        output o_beam_idx, o_beam_pwr, o_tvalid, o_tlast, o_busy, o_drop
    );
endinterface

// File: rtl/beam_topk_sel_topk_insert.sv
// topk_insert: K-slot list held in descending power order.
//   clk_i, rst_n_i   - clock, async active-low reset (empties the list)
//   clr_i            - empty the list (takes priority over ins_i)
//   ins_i            - insert cand_pwr_i/cand_idx_i this cycle
//   rd_addr_i        - slot to read; rd_pwr_o/rd_idx_o are combinational
// Equal powers do not displace, so earlier candidates stay ahead on ties.
module topk_insert
    import beam_sel_pkg::*;
#(
    parameter int K  = 16,
    parameter int AW = 51,
    parameter int BW = 6,
    parameter int KW = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          ins_i,
    input  logic [AW-1:0] cand_pwr_i,
    input  logic [BW-1:0] cand_idx_i,
    input  logic [KW-1:0] rd_addr_i,
    output logic [AW-1:0] rd_pwr_o,
    output logic [BW-1:0] rd_idx_o
);

    topk_entry_t slot_q [K];
    topk_entry_t cand;
    logic [K-1:0] take;

    // take[] is monotone over the slots (valid entries descend, empty slots
    // sit at the tail), so the insert point is its first set bit.
    always_comb begin
        cand.pwr = PWR_W_MAX'(cand_pwr_i);
        cand.idx = IDX_W_MAX'(cand_idx_i);
        cand.vld = 1'b1;
        for (int j = 0; j < K; j++) begin
            take[j] = !slot_q[j].vld || (slot_q[j].pwr < cand.pwr);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int j = 0; j < K; j++) slot_q[j] <= '0;
        end else if (clr_i) begin
            for (int j = 0; j < K; j++) slot_q[j].vld <= 1'b0;
        end else if (ins_i) begin
            if (take[0]) slot_q[0] <= cand;
            for (int j = 1; j < K; j++) begin
                if (take[j]) slot_q[j] <= take[j-1] ? slot_q[j-1] : cand;
            end
        end
    end

    assign rd_pwr_o = slot_q[rd_addr_i].pwr[AW-1:0];
    assign rd_idx_o = slot_q[rd_addr_i].idx[BW-1:0];

endmodule

// File: rtl/beam_topk_sel.sv
// beam_topk_sel: accumulates NBEAM beam magnitudes over NRND rounds, then
// streams the K strongest beams (index + accumulated power), strongest first.
//   i_clk, i_rst_n - clock, async active-low reset
//   bus (slave)    - input magnitude stream, output beam stream, busy/drop
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for a valid beat with i_sof; other beats dropped
// ST_ACC  | accumulating beats into acc_mem; i_sof restarts the frame
// ST_SORT | one accumulated beam per cycle fed into the top-K list
// ST_OUT  | K output beats from the list, slot 0 first
module beam_topk_sel
    import beam_sel_pkg::*;
#(
    parameter int NBEAM = 64,
    parameter int NRND  = 4,
    parameter int IW    = 48,
    parameter int K     = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    beam_topk_sel_if.slave  bus
);

    localparam int BW = $clog2(NBEAM);
    localparam int AW = IW + $clog2(NRND) + 1;
    localparam int RW = clog2_min1(NRND);
    localparam int KW = clog2_min1(K);

    state_t        state_q;
    logic [BW-1:0] beam_cnt_q;
    logic [RW-1:0] rnd_cnt_q;
    logic [KW-1:0] out_cnt_q;
    logic          tvalid_q;
    logic          tlast_q;
    logic          drop_q;

    logic [AW-1:0] acc_mem [NBEAM];

    logic          beat_acc;
    logic          drop_now;
    logic [BW-1:0] cur_beam;
    logic [RW-1:0] cur_rnd;
    logic          last_beam;
    logic          last_rnd;
    logic [BW-1:0] rd_addr;
    logic [AW-1:0] rd_data;
    logic [AW-1:0] wr_data;
    logic          list_clr;
    logic [AW-1:0] list_pwr;
    logic [BW-1:0] list_idx;

    // An i_sof beat is always beam 0 / round 0, whatever the counters hold.
    always_comb begin
        beat_acc  = bus.i_tvalid && ((state_q == ST_ACC) ||
                                     (state_q == ST_IDLE && bus.i_sof));
        drop_now  = bus.i_tvalid && ((state_q == ST_IDLE && !bus.i_sof) ||
                                     (state_q == ST_SORT) || (state_q == ST_OUT));
        cur_beam  = bus.i_sof ? '0 : beam_cnt_q;
        cur_rnd   = bus.i_sof ? '0 : rnd_cnt_q;
        last_beam = (cur_beam == BW'(NBEAM - 1));
        last_rnd  = (cur_rnd == RW'(NRND - 1));
        rd_addr   = (state_q == ST_SORT) ? beam_cnt_q : cur_beam;
        rd_data   = acc_mem[rd_addr];
        // Round 0 overwrites, so stale sums from the previous frame vanish.
        wr_data   = (cur_rnd == '0) ? AW'(bus.i_sum_data)
                                    : rd_data + AW'(bus.i_sum_data);
        list_clr  = beat_acc && last_beam && last_rnd;
    end

    always_ff @(posedge i_clk) begin
        if (beat_acc) acc_mem[cur_beam] <= wr_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            beam_cnt_q <= '0;
            rnd_cnt_q  <= '0;
            out_cnt_q  <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= drop_now;
            case (state_q)
                ST_IDLE, ST_ACC: begin
                    if (beat_acc) begin
                        if (last_beam) begin
                            beam_cnt_q <= '0;
                            if (last_rnd) begin
                                rnd_cnt_q <= '0;
                                state_q   <= ST_SORT;
                            end else begin
                                rnd_cnt_q <= cur_rnd + RW'(1);
                                state_q   <= ST_ACC;
                            end
                        end else begin
                            beam_cnt_q <= cur_beam + BW'(1);
                            rnd_cnt_q  <= cur_rnd;
                            state_q    <= ST_ACC;
                        end
                    end
                end
                ST_SORT: begin
                    if (beam_cnt_q == BW'(NBEAM - 1)) begin
                        beam_cnt_q <= '0;
                        out_cnt_q  <= '0;
                        tvalid_q   <= 1'b1;
                        tlast_q    <= (K == 1);
                        state_q    <= ST_OUT;
                    end else begin
                        beam_cnt_q <= beam_cnt_q + BW'(1);
                    end
                end
                ST_OUT: begin
                    if (out_cnt_q == KW'(K - 1)) begin
                        out_cnt_q <= '0;
                        tvalid_q  <= 1'b0;
                        tlast_q   <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        out_cnt_q <= out_cnt_q + KW'(1);
                        tlast_q   <= ((out_cnt_q + KW'(1)) == KW'(K - 1));
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    topk_insert #(
        .K  (K),
        .AW (AW),
        .BW (BW),
        .KW (KW)
    ) u_topk (
        .clk_i      (i_clk),
        .rst_n_i    (i_rst_n),
        .clr_i      (list_clr),
        .ins_i      (state_q == ST_SORT),
        .cand_pwr_i (rd_data),
        .cand_idx_i (beam_cnt_q),
        .rd_addr_i  (out_cnt_q),
        .rd_pwr_o   (list_pwr),
        .rd_idx_o   (list_idx)
    );

    assign bus.o_tvalid   = tvalid_q;
    assign bus.o_tlast    = tlast_q;
    assign bus.o_beam_idx = tvalid_q ? list_idx : '0;
    assign bus.o_beam_pwr = tvalid_q ? list_pwr : '0;
    assign bus.o_busy     = (state_q == ST_SORT) || (state_q == ST_OUT);
    assign bus.o_drop     = drop_q;

endmodule

// File: tb/tb_beam_topk_sel.sv
module tb_beam_topk_sel;

    localparam int NBEAM = 8;
    localparam int NRND  = 2;
    localparam int IW    = 16;
    localparam int K     = 3;
    localparam int BW    = 3;
    localparam int AW    = 18;
    localparam int NB    = NBEAM * NRND;

    typedef struct packed {
        logic [NBEAM-1:0][IW-1:0] r0;
        logic [NBEAM-1:0][IW-1:0] r1;
        logic                     gaps;
        logic [K-1:0][BW-1:0]     e_idx;
        logic [K-1:0][AW-1:0]     e_pwr;
    } vec_t;

    logic clk;
    logic rst_n;

    beam_topk_sel_if #(.IW(IW), .BW(BW), .AW(AW)) bus ();

    beam_topk_sel #(.NBEAM(NBEAM), .NRND(NRND), .IW(IW), .K(K)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [BW-1:0] q_idx [$];
    logic [AW-1:0] q_pwr [$];
    bit            q_last[$];
    int            q_cyc [$];
    int            drop_cnt = 0;

    always @(negedge clk) begin
        if (bus.o_tvalid) begin
            q_idx.push_back(bus.o_beam_idx);
            q_pwr.push_back(bus.o_beam_pwr);
            q_last.push_back(bus.o_tlast);
            q_cyc.push_back(cyc);
        end
        if (bus.o_drop) drop_cnt++;
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    int frm [NB];
    int last_in = 0;
    vec_t tbl [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        q_idx.delete(); q_pwr.delete(); q_last.delete(); q_cyc.delete();
    endtask

    task automatic load_vec(input int v);
        for (int b = 0; b < NBEAM; b++) begin
            frm[b]         = int'(tbl[v].r0[b]);
            frm[NBEAM + b] = int'(tbl[v].r1[b]);
        end
    endtask

    // Reference: per-beam sums, then K passes picking the largest unused sum;
    // the strict '>' keeps the lowest index on ties.
    task automatic model(output logic [K-1:0][BW-1:0] ei, output logic [K-1:0][AW-1:0] ep);
        int  sum [NBEAM];
        bit  used[NBEAM];
        int  best;
        for (int b = 0; b < NBEAM; b++) begin
            sum[b] = 0;
            used[b] = 1'b0;
            for (int r = 0; r < NRND; r++) sum[b] += frm[r*NBEAM + b];
        end
        for (int k = 0; k < K; k++) begin
            best = -1;
            for (int b = 0; b < NBEAM; b++)
                if (!used[b] && (best < 0 || sum[b] > sum[best])) best = b;
            used[best] = 1'b1;
            ei[k] = BW'(best);
            ep[k] = AW'(sum[best]);
        end
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < NB; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.i_tvalid = 1'b0;
                    bus.i_sof = 1'b0;
                    bus.i_sum_data = IW'($urandom);
                    tick();
                end
            end
            bus.i_tvalid = 1'b1;
            bus.i_sof = (i == 0);
            bus.i_sum_data = IW'(frm[i]);
            last_in = cyc;
            tick();
        end
        bus.i_tvalid = 1'b0;
        bus.i_sof = 1'b0;
    endtask

    task automatic collect(input string nm, input logic [K-1:0][BW-1:0] ei,
                           input logic [K-1:0][AW-1:0] ep);
        bit ok = 1'b0;
        for (int c = 0; c < NBEAM + K + 20; c++) begin
            if (q_idx.size() >= K) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk($sformatf("%s_done", nm), 64'(ok), 64'd1);
        if (ok) begin
            tick();
            tick();
            chk($sformatf("%s_nbeats", nm), 64'(q_idx.size()), 64'(K));
            for (int j = 0; j < K; j++) begin
                chk($sformatf("%s_idx%0d", nm, j), 64'(q_idx[j]), 64'(ei[j]));
                chk($sformatf("%s_pwr%0d", nm, j), 64'(q_pwr[j]), 64'(ep[j]));
                chk($sformatf("%s_last%0d", nm, j), 64'(q_last[j]), 64'(j == K - 1));
            end
            chk($sformatf("%s_lat_first", nm), 64'(q_cyc[0] - last_in), 64'(NBEAM + 1));
            chk($sformatf("%s_lat_last", nm), 64'(q_cyc[K-1] - last_in), 64'(NBEAM + K));
        end
        flush();
    endtask

    initial begin
        logic [K-1:0][BW-1:0] ei;
        logic [K-1:0][AW-1:0] ep;
        int d0;
        bit ok;

        tbl[0].r0 = {16'd60, 16'd40, 16'd70, 16'd30, 16'd90, 16'd20, 16'd50, 16'd10};
        tbl[0].r1 = {16'd60, 16'd40, 16'd70, 16'd30, 16'd90, 16'd20, 16'd50, 16'd10};
        tbl[0].gaps = 1'b0;
        tbl[0].e_idx = {3'd7, 3'd5, 3'd3};
        tbl[0].e_pwr = {18'd120, 18'd140, 18'd180};

        tbl[1].r0 = {8{16'd5}};
        tbl[1].r1 = {8{16'd5}};
        tbl[1].gaps = 1'b0;
        tbl[1].e_idx = {3'd2, 3'd1, 3'd0};
        tbl[1].e_pwr = {3{18'd10}};

        tbl[2].r0 = {8{16'hFFFF}};
        tbl[2].r1 = {8{16'hFFFF}};
        tbl[2].gaps = 1'b1;
        tbl[2].e_idx = {3'd2, 3'd1, 3'd0};
        tbl[2].e_pwr = {3{18'h1FFFE}};

        tbl[3].r0 = {{7{16'd0}}, 16'd100};
        tbl[3].r1 = {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
        tbl[3].gaps = 1'b0;
        tbl[3].e_idx = {3'd6, 3'd7, 3'd0};
        tbl[3].e_pwr = {18'd6, 18'd7, 18'd100};

        rst_n = 1'b0;
        bus.i_tvalid = 1'b0;
        bus.i_sof = 1'b0;
        bus.i_sum_data = '0;
        repeat (3) tick();
        chk("rst_tvalid", 64'(bus.o_tvalid), 64'd0);
        chk("rst_tlast", 64'(bus.o_tlast), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_drop", 64'(bus.o_drop), 64'd0);
        chk("rst_idx", 64'(bus.o_beam_idx), 64'd0);
        chk("rst_pwr", 64'(bus.o_beam_pwr), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) begin
            load_vec(v);
            send_frame(tbl[v].gaps);
            collect($sformatf("vec%0d", v), tbl[v].e_idx, tbl[v].e_pwr);
        end

        // Mid-frame restart: five heavy beats, then a fresh frame with i_sof.
        d0 = drop_cnt;
        for (int i = 0; i < 5; i++) begin
            bus.i_tvalid = 1'b1;
            bus.i_sof = (i == 0);
            bus.i_sum_data = 16'd30000;
            tick();
        end
        load_vec(0);
        send_frame(1'b0);
        collect("restart", tbl[0].e_idx, tbl[0].e_pwr);
        chk("restart_nodrop", 64'(drop_cnt - d0), 64'd0);

        // Beats during SORT are dropped and do not disturb the result.
        d0 = drop_cnt;
        load_vec(1);
        send_frame(1'b0);
        chk("sort_busy", 64'(bus.o_busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            bus.i_tvalid = 1'b1;
            bus.i_sof = (i == 0);
            bus.i_sum_data = 16'hFFFF;
            tick();
        end
        bus.i_tvalid = 1'b0;
        bus.i_sof = 1'b0;
        collect("busydrop", tbl[1].e_idx, tbl[1].e_pwr);
        chk("busydrop_cnt", 64'(drop_cnt - d0), 64'd4);

        d0 = drop_cnt;
        bus.i_tvalid = 1'b1;
        bus.i_sof = 1'b0;
        bus.i_sum_data = 16'd77;
        tick();
        bus.i_tvalid = 1'b0;
        repeat (3) tick();
        chk("idle_drop_cnt", 64'(drop_cnt - d0), 64'd1);

        // Async reset during the second output beat.
        load_vec(0);
        send_frame(1'b0);
        ok = 1'b0;
        for (int c = 0; c < NBEAM + K + 20; c++) begin
            if (q_idx.size() >= 1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("rstout_first_beat", 64'(ok), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstout_tvalid", 64'(bus.o_tvalid), 64'd0);
        chk("rstout_busy", 64'(bus.o_busy), 64'd0);
        chk("rstout_tlast", 64'(bus.o_tlast), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        flush();

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NB; i++)
                frm[i] = (r == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 65535));
            model(ei, ep);
            send_frame(r[0]);
            collect($sformatf("rand%0d", r), ei, ep);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
